ccip_rd_reorder: RTL and testbench
==================================

Name: ccip_rd_reorder

Overview:
- Sits between the read-request side of the server system and the CCI-P c0 channel.
- Tags each read with a sequential mdata value and issues it on c0 with the request header registered.
- Collects CCI-P read responses, which may return out of order, into a tag-indexed buffer.
- Returns the response data strictly in request order through a valid/ready interface.

Parameters:
- TAG_W, 6, tag width; DEPTH = 2**TAG_W outstanding reads (64).
- ADDR_W, 64, request address width.
- DATA_W, 512, cache-line data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  upstream read request valid.
- req_addr  in  ADDR_W  line address.
- req_ready  out  1  request accepted when req_valid && req_ready.
- c0_tx_valid  out  1  registered CCI-P c0 request valid.
- c0_tx_addr  out  ADDR_W  registered request address.
- c0_tx_mdata  out  16  registered mdata; tag in [TAG_W-1:0], upper bits 0.
- c0_tx_almfull  in  1  CCI-P c0TxAlmFull.
- c0_rx_valid  in  1  read response valid; caller has already excluded MMIO.
- c0_rx_mdata  in  16  response mdata.
- c0_rx_data  in  DATA_W  response line.
- rsp_valid  out  1  in-order response valid.
- rsp_data  out  DATA_W  in-order response data.
- rsp_ready  in  1  downstream accept.
- outstanding  out  TAG_W+1  reads issued and not yet popped.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n low, async): all outputs 0; issue_ptr=0, head_ptr=0, count=0; all slot-valid bits 0; err=0. Buffer RAM contents are not reset.
- req_ready = !c0_tx_almfull && (count < DEPTH). Purely combinational from registered state plus almfull.
- Issue: on accept, the next edge sets c0_tx_valid=1, c0_tx_addr=req_addr, c0_tx_mdata={zeros, issue_ptr}, and issue_ptr+1 (wraps mod DEPTH). c0_tx_valid is 0 in cycles without an accept.
- Issue latency: exactly 1 cycle from accept to c0_tx_valid.
- Response capture, when c0_rx_valid:
  - tag = c0_rx_mdata[TAG_W-1:0].
  - If mdata[15:TAG_W] is nonzero, or slot tag is not outstanding, or slot tag is already valid: drop the response and set err.
  - Otherwise write data to RAM[tag] and set valid[tag].
- Outstanding test for tag t: ((t - head_ptr) mod DEPTH) < count.
- Output stage:
  - rsp_valid=1 when valid[head_ptr]; rsp_data=RAM[head_ptr].
  - Read path may be a registered RAM read; rsp_data must be stable while rsp_valid && !rsp_ready.
- Response latency: a response landing on the head slot at edge N gives rsp_valid at edge N+1 at the earliest. N+2 is allowed with a registered RAM; it is fixed per build and documented.
- Pop: on rsp_valid && rsp_ready, clear valid[head_ptr] and advance head_ptr (wraps mod DEPTH).
- Count: +1 on accept, -1 on pop, unchanged when both occur in the same cycle. outstanding = count.
- Simultaneous capture and pop:
  - Always on different tags (the head slot cannot be re-captured before its pop).
  - Both take effect in the same edge.
  - A capture to slot head_ptr+1 during a pop of head_ptr is presented the cycle after the pop at the earliest.
- Full: count==DEPTH forces req_ready=0, even with almfull low. Issue resumes the cycle after a pop.
- Almfull asserted while c0_tx_valid=1: the registered request still goes out (CCI-P allows up to 8 requests after almfull); no new accept.
- Backpressure: rsp_ready=0 holds the head, and capture into other slots continues.
- Reset mid-operation: all state is cleared asynchronously. Responses that return after reset to non-outstanding tags set err and are dropped.

Decomposition:
- Shared package ccip_rd_pkg: TAG_W default, typedef t_rd_tag, typedef t_cl_data (512-bit), constant MDATA_W=16.
- One sub-module, rd_tag_buffer: a DEPTH x DATA_W simple dual-port RAM (write on capture, read at head) plus the slot-valid bit vector with set/clear ports.
- Top level holds the pointers, count, issue register and err.

Test Plan:
- Reset, then 4 requests at addr 0x1000..0x1003 with almfull=0 -> c0_tx_valid on 4 consecutive cycles, mdata 0,1,2,3. Responses returned in order 3,1,0,2 with data=0xA3,0xA1,0xA0,0xA2 -> rsp_data sequence 0xA0,0xA1,0xA2,0xA3. rsp_valid first asserts the cycle after tag 0 arrives.
- Issue 64 requests with no responses -> req_ready=0 at count=64 and outstanding=64. Return tag 0 and pop it -> req_ready=1 the next cycle, and the next request carries mdata=0 (wrap).
- Hold almfull=1 for 10 cycles while req_valid=1 -> no accepts and c0_tx_valid=0 after the in-flight one. Drop almfull -> issue resumes with the next sequential tag.
- Hold rsp_ready=0 while tags 0..7 return -> rsp_valid held with data of tag 0. Then rsp_ready=1 continuously -> 8 pops on 8 consecutive cycles, outstanding goes to 0.
- Response with mdata=0x0045 (upper bit set), a second response for an already-valid tag, and a response for a non-outstanding tag -> each dropped, err=1 and sticky, in-order data for legitimate tags unaffected.
- Assert rst_n low mid-burst with 5 outstanding -> all outputs 0 immediately (async). After release, a late response to tag 2 sets err, and a new request issues mdata=0.

Source files
------------

// File: rtl/ccip_rd_pkg.sv
// Shared types and sizing for the CCI-P read reorder block.
package ccip_rd_pkg;

    localparam int RD_TAG_W  = 6;
    localparam int RD_DEPTH  = 1 << RD_TAG_W;
    localparam int RD_ADDR_W = 64;
    localparam int RD_DATA_W = 512;
    localparam int MDATA_W   = 16;

    typedef logic [RD_TAG_W-1:0]  t_rd_tag;
    typedef logic [RD_DATA_W-1:0] t_cl_data;

endpackage

// File: rtl/ccip_rd_reorder_if.sv
// Request, CCI-P c0 and in-order response signals of the read reorder block.
interface ccip_rd_reorder_if #(
    parameter int TAG_W  = ccip_rd_pkg::RD_TAG_W,
    parameter int ADDR_W = ccip_rd_pkg::RD_ADDR_W,
    parameter int DATA_W = ccip_rd_pkg::RD_DATA_W
);

    logic                           req_valid;
    logic [ADDR_W-1:0]              req_addr;
    logic                           req_ready;
    logic                           c0_tx_valid;
    logic [ADDR_W-1:0]              c0_tx_addr;
    logic [ccip_rd_pkg::MDATA_W-1:0] c0_tx_mdata;
    logic                           c0_tx_almfull;
    logic                           c0_rx_valid;
    logic [ccip_rd_pkg::MDATA_W-1:0] c0_rx_mdata;
    logic [DATA_W-1:0]              c0_rx_data;
    logic                           rsp_valid;
    logic [DATA_W-1:0]              rsp_data;
    logic                           rsp_ready;
    logic [TAG_W:0]                 outstanding;
    logic                           err;

    // Environment side: request source, CCI-P shell and response sink.
    modport master (
        output req_valid, req_addr, c0_tx_almfull, c0_rx_valid, c0_rx_mdata,
               c0_rx_data, rsp_ready,
        input  req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata, rsp_valid,
               rsp_data, outstanding, err
    );

    modport slave (
        input  req_valid, req_addr, c0_tx_almfull, c0_rx_valid, c0_rx_mdata,
               c0_rx_data, rsp_ready,
        output req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata, rsp_valid,
               rsp_data, outstanding, err
    );

endinterface

// File: rtl/rd_tag_buffer.sv
// Tag-indexed response store: DEPTH x DATA_W RAM plus per-slot valid bits.
module rd_tag_buffer #(
    parameter int TAG_W  = ccip_rd_pkg::RD_TAG_W,
    parameter int DATA_W = ccip_rd_pkg::RD_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              clr_en_i,
    input  logic [TAG_W-1:0]  clr_tag_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [(1<<TAG_W)-1:0] slot_valid_o
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Set and clear never target the same slot: a valid slot refuses capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (clr_en_i) valid_q[clr_tag_i] <= 1'b0;
            if (wr_en_i)  valid_q[wr_tag_i]  <= 1'b1;
        end
    end

    // NOTE: storage has no reset; a slot's contents are only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_tag_i] <= wr_data_i;
    end

    assign rd_valid_o   = valid_q[rd_tag_i];
    assign rd_data_o    = mem_q[rd_tag_i];
    assign slot_valid_o = valid_q;

endmodule

// File: rtl/ccip_rd_reorder.sv
// Tags reads onto CCI-P c0 and returns their responses in request order.
// Head read is combinational: a capture into the head slot shows on rsp_valid the next cycle.
module ccip_rd_reorder #(
    parameter int TAG_W  = ccip_rd_pkg::RD_TAG_W,
    parameter int ADDR_W = ccip_rd_pkg::RD_ADDR_W,
    parameter int DATA_W = ccip_rd_pkg::RD_DATA_W
) (
    input logic              clk,
    input logic              rst_n,
    ccip_rd_reorder_if.slave bus
);

    import ccip_rd_pkg::*;

    localparam int DEPTH = 1 << TAG_W;

    logic [TAG_W-1:0]   issue_ptr_q, issue_ptr_d;
    logic [TAG_W-1:0]   head_ptr_q, head_ptr_d;
    logic [TAG_W:0]     count_q, count_d;
    logic               err_q, err_d;
    logic               c0_tx_valid_q;
    logic [ADDR_W-1:0]  c0_tx_addr_q;
    logic [MDATA_W-1:0] c0_tx_mdata_q;

    logic               accept, pop, cap_ok;
    logic               rx_hi_bad, rx_outstanding;
    logic [TAG_W-1:0]   rx_tag, rx_dist;
    logic [DEPTH-1:0]   slot_valid;
    logic               head_valid;
    logic [DATA_W-1:0]  head_data;

    assign bus.req_ready = !bus.c0_tx_almfull && (count_q < (TAG_W+1)'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = head_valid && bus.rsp_ready;

    // A tag is live when its distance from the head is below the in-flight count.
    assign rx_tag         = bus.c0_rx_mdata[TAG_W-1:0];
    assign rx_hi_bad      = |bus.c0_rx_mdata[MDATA_W-1:TAG_W];
    assign rx_dist        = rx_tag - head_ptr_q;
    assign rx_outstanding = {1'b0, rx_dist} < count_q;
    assign cap_ok         = bus.c0_rx_valid && !rx_hi_bad && rx_outstanding
                            && !slot_valid[rx_tag];

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path infers a latch.
        issue_ptr_d = issue_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        err_d       = err_q | (bus.c0_rx_valid && !cap_ok);
        if (accept) issue_ptr_d = issue_ptr_q + 1'b1;
        if (pop)    head_ptr_d  = head_ptr_q + 1'b1;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_ptr_q   <= '0;
            head_ptr_q    <= '0;
            count_q       <= '0;
            err_q         <= 1'b0;
            c0_tx_valid_q <= 1'b0;
            c0_tx_addr_q  <= '0;
            c0_tx_mdata_q <= '0;
        end else begin
            issue_ptr_q   <= issue_ptr_d;
            head_ptr_q    <= head_ptr_d;
            count_q       <= count_d;
            err_q         <= err_d;
            c0_tx_valid_q <= accept;
            if (accept) begin
                c0_tx_addr_q  <= bus.req_addr;
                c0_tx_mdata_q <= {{(MDATA_W-TAG_W){1'b0}}, issue_ptr_q};
            end
        end
    end

    rd_tag_buffer #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (cap_ok),
        .wr_tag_i     (rx_tag),
        .wr_data_i    (bus.c0_rx_data),
        .clr_en_i     (pop),
        .clr_tag_i    (head_ptr_q),
        .rd_tag_i     (head_ptr_q),
        .rd_valid_o   (head_valid),
        .rd_data_o    (head_data),
        .slot_valid_o (slot_valid)
    );

    assign bus.c0_tx_valid = c0_tx_valid_q;
    assign bus.c0_tx_addr  = c0_tx_addr_q;
    assign bus.c0_tx_mdata = c0_tx_mdata_q;
    assign bus.rsp_valid   = head_valid;
    assign bus.rsp_data    = head_valid ? head_data : '0;
    assign bus.outstanding = count_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_ccip_rd_reorder.sv
// Self-checking bench for ccip_rd_reorder: vector table plus issue/response scoreboards.
module tb_ccip_rd_reorder;

    import ccip_rd_pkg::*;

    typedef struct {
        logic [15:0] mdata;
        logic [31:0] data;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [RD_ADDR_W-1:0] addr;
        logic [15:0]          mdata;
    } iss_t;

    typedef struct {
        t_rd_tag  tag;
        t_cl_data data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ccip_rd_reorder_if bus ();

    ccip_rd_reorder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int       vec_cnt = 0;
    int       miss_cnt = 0;
    iss_t     iss_q[$];
    rsp_t     rsp_q[$];
    t_cl_data slot_data [RD_DEPTH];
    t_rd_tag  model_issue = '0;
    vec_t     vecs [9];

    task automatic check(input string name, input logic [RD_DATA_W-1:0] act,
                         input logic [RD_DATA_W-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: c0 requests and in-order pops are compared as they appear.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.c0_tx_valid) begin
                if (iss_q.size() == 0) begin
                    check("c0_unexpected", bus.c0_tx_valid, 1'b0);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("c0_addr", bus.c0_tx_addr, e.addr);
                    check("c0_mdata", bus.c0_tx_mdata, e.mdata);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", bus.rsp_valid, 1'b0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_data", bus.rsp_data, r.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string p);
        check({p, "_c0_valid"}, bus.c0_tx_valid, 0);
        check({p, "_c0_addr"}, bus.c0_tx_addr, 0);
        check({p, "_c0_mdata"}, bus.c0_tx_mdata, 0);
        check({p, "_rsp_valid"}, bus.rsp_valid, 0);
        check({p, "_rsp_data"}, bus.rsp_data, 0);
        check({p, "_outstanding"}, bus.outstanding, 0);
        check({p, "_err"}, bus.err, 0);
    endtask

    task automatic reset_dut(input bit now);
        if (!now) @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.c0_rx_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.c0_tx_almfull = 1'b0;
        iss_q.delete();
        rsp_q.delete();
        model_issue = '0;
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc();
        check("rst_req_ready", bus.req_ready, 1'b1);
    endtask

    // Leaves req_valid high so consecutive calls issue back-to-back.
    task automatic issue_one(input logic [RD_ADDR_W-1:0] addr, input t_cl_data data);
        bit ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = addr;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("req_ready_timeout", bus.req_ready, 1'b1);
        end else begin
            iss_q.push_back('{addr: addr, mdata: {10'b0, model_issue}});
            rsp_q.push_back('{tag: model_issue, data: data});
            slot_data[model_issue] = data;
            model_issue = model_issue + 1'b1;
        end
        cyc();
    endtask

    task automatic respond(input t_rd_tag tag);
        bus.c0_rx_valid = 1'b1;
        bus.c0_rx_mdata = {10'b0, tag};
        bus.c0_rx_data = slot_data[tag];
        cyc();
        bus.c0_rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string p);
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (bus.outstanding == 0) break;
        end
        check({p, "_drain_outstanding"}, bus.outstanding, 0);
        check({p, "_drain_left"}, rsp_q.size(), 0);
        cyc();
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.c0_rx_valid = 1'b1;
            bus.c0_rx_mdata = vecs[i].mdata;
            bus.c0_rx_data = RD_DATA_W'(vecs[i].data);
            cyc();
            bus.c0_rx_valid = 1'b0;
            check($sformatf("vec%0d_rsp_valid", i), bus.rsp_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_rsp_data", i), bus.rsp_data, RD_DATA_W'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i), bus.err, vecs[i].exp_err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t_rd_tag order[$];
        t_rd_tag tmp;
        int      j;

        // Out-of-order return 3,1,0,2 with rsp_ready low, then illegal responses.
        vecs[0] = '{16'h0003, 32'hA3, 1'b0, 32'h0,  1'b0};
        vecs[1] = '{16'h0001, 32'hA1, 1'b0, 32'h0,  1'b0};
        vecs[2] = '{16'h0000, 32'hA0, 1'b1, 32'hA0, 1'b0};
        vecs[3] = '{16'h0002, 32'hA2, 1'b1, 32'hA0, 1'b0};
        vecs[4] = '{16'h0045, 32'hEE, 1'b0, 32'h0,  1'b1};
        vecs[5] = '{16'h0004, 32'hB4, 1'b1, 32'hB4, 1'b1};
        vecs[6] = '{16'h0004, 32'hEE, 1'b1, 32'hB4, 1'b1};
        vecs[7] = '{16'h0009, 32'hEE, 1'b1, 32'hB4, 1'b1};
        vecs[8] = '{16'h0005, 32'hB5, 1'b1, 32'hB4, 1'b1};

        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.c0_tx_almfull = 1'b0;
        bus.c0_rx_valid = 1'b0;
        bus.c0_rx_mdata = '0;
        bus.c0_rx_data = '0;
        bus.rsp_ready = 1'b0;

        reset_dut(1'b0);
        for (int i = 0; i < 4; i++) issue_one(64'h1000 + 64'(i), RD_DATA_W'(32'hA0 + i));
        bus.req_valid = 1'b0;
        check("t1_outstanding", bus.outstanding, 4);
        apply_vecs(0, 3);
        wait_drain("t1");

        bus.rsp_ready = 1'b0;
        issue_one(64'h1100, RD_DATA_W'(32'hB4));
        issue_one(64'h1101, RD_DATA_W'(32'hB5));
        bus.req_valid = 1'b0;
        apply_vecs(4, 8);
        wait_drain("errt");
        check("err_sticky", bus.err, 1'b1);

        // Fill all 64 tags, then free one slot and confirm the tag wraps.
        reset_dut(1'b0);
        for (int i = 0; i < RD_DEPTH; i++)
            issue_one(64'h2000 + 64'(i), {16{$urandom()}});
        bus.req_addr = 64'h3000;
        @(negedge clk);
        check("full_req_ready", bus.req_ready, 1'b0);
        check("full_outstanding", bus.outstanding, RD_DEPTH);
        repeat (3) cyc();
        bus.req_valid = 1'b0;
        respond(t_rd_tag'(0));
        check("full_head_valid", bus.rsp_valid, 1'b1);
        check("full_head_data", bus.rsp_data, slot_data[0]);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("full_ready_before_pop", bus.req_ready, 1'b0);
        cyc();
        bus.rsp_ready = 1'b0;
        check("pop_outstanding", bus.outstanding, RD_DEPTH - 1);
        check("pop_req_ready", bus.req_ready, 1'b1);
        issue_one(64'h3000, {16{$urandom()}});
        bus.req_valid = 1'b0;
        check("wrap_mdata", bus.c0_tx_mdata, 16'h0000);
        foreach (rsp_q[k]) order.push_back(rsp_q[k].tag);
        for (int i = order.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        foreach (order[k]) begin
            bus.rsp_ready = 1'($urandom_range(1, 0));
            respond(order[k]);
        end
        wait_drain("full");

        // Almost-full: the in-flight request leaves, nothing new is accepted.
        issue_one(64'h4000, {16{$urandom()}});
        bus.req_addr = 64'h4001;
        bus.c0_tx_almfull = 1'b1;
        check("alm_inflight", bus.c0_tx_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("alm_req_ready", bus.req_ready, 1'b0);
            cyc();
        end
        check("alm_c0_valid", bus.c0_tx_valid, 1'b0);
        check("alm_outstanding", bus.outstanding, 1);
        bus.c0_tx_almfull = 1'b0;
        issue_one(64'h4001, {16{$urandom()}});
        issue_one(64'h4002, {16{$urandom()}});
        bus.req_valid = 1'b0;
        order.delete();
        foreach (rsp_q[k]) order.push_front(rsp_q[k].tag);
        foreach (order[k]) respond(order[k]);
        wait_drain("alm");

        // Backpressure: head held while later tags are captured, then 8 back-to-back pops.
        reset_dut(1'b0);
        for (int i = 0; i < 8; i++) issue_one(64'h6000 + 64'(i), {16{$urandom()}});
        bus.req_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            respond(t_rd_tag'(t));
            check("bp_valid", bus.rsp_valid, 1'b1);
            check("bp_data", bus.rsp_data, slot_data[0]);
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_pop_valid", bus.rsp_valid, 1'b1);
            cyc();
        end
        check("bp_outstanding", bus.outstanding, 0);
        bus.rsp_ready = 1'b0;

        // Asynchronous reset with 5 reads in flight.
        for (int i = 0; i < 5; i++) issue_one(64'h7000 + 64'(i), {16{$urandom()}});
        bus.req_valid = 1'b0;
        check("mid_inflight", bus.c0_tx_valid, 1'b1);
        check("mid_outstanding", bus.outstanding, 5);
        reset_dut(1'b1);
        respond(t_rd_tag'(2));
        check("mid_late_err", bus.err, 1'b1);
        check("mid_late_valid", bus.rsp_valid, 1'b0);
        check("mid_late_outstanding", bus.outstanding, 0);
        issue_one(64'h5000, {16{$urandom()}});
        bus.req_valid = 1'b0;
        check("mid_mdata", bus.c0_tx_mdata, 16'h0000);
        respond(t_rd_tag'(0));
        wait_drain("mid");
        check("mid_err_sticky", bus.err, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
